// File: rtl/switch_debounce.sv
// switch_debounce: synchronize, debounce and edge-detect a bank of mechanical switches for a PIO.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sw_raw       raw bouncing switch levels (asynchronous)
//   sw_out       debounced levels
//   rise_pulse   one-cycle pulse per bit on a debounced 0->1
//   fall_pulse   one-cycle pulse per bit on a debounced 1->0
//   edge_clr     write-1-to-clear strobe for edge_capture
//   irq_mask     per-bit interrupt enable
//   edge_capture sticky record of debounced edges
//   irq          registered OR of edge_capture & irq_mask
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic [WIDTH-1:0] edge_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // The counter tracks how long s2 has disagreed with sw_out; reaching LAST
    // while still disagreeing commits the new level, so it can never wrap.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] count;
        assign flip[i] = (s2[i] != sw_out[i]) && (count == LAST);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                count <= '0;
            else
                count <= (s2[i] == sw_out[i] || flip[i]) ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        rise_next = flip & ~sw_out;
        fall_next = flip & sw_out;
    end

    // Setting edge_capture is OR-ed in after the clear so a simultaneous set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_out       <= '0;
            rise_pulse   <= '0;
            fall_pulse   <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            sw_out       <= sw_out ^ flip;
            rise_pulse   <= rise_next;
            fall_pulse   <= fall_next;
            edge_capture <= (edge_capture & ~edge_clr) | rise_next | fall_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scoreboard bench for switch_debounce with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_switch_debounce;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [7:0] sw;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] cap;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = 8'hFF;
    logic [W-1:0] edge_clr = 8'h00;
    logic [W-1:0] irq_mask = 8'hFF;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] edge_capture;
    logic         irq;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t q[$];

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_out(sw_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .edge_clr(edge_clr),
        .irq_mask(irq_mask),
        .edge_capture(edge_capture),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called in the cycle the new level is applied; the edge shows N+2 edges later.
    task automatic expect_ev(input logic [7:0] sw, input logic [7:0] rise,
                             input logic [7:0] fall, input logic [7:0] cap);
        q.push_back('{cyc + N + 2, sw, rise, fall, cap});
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if ((rise_pulse | fall_pulse) != '0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: rise=%0h fall=%0h at cycle %0d, none expected",
                         rise_pulse, fall_pulse, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_sw_out", sw_out, e.sw);
                chk("ev_rise", rise_pulse, e.rise);
                chk("ev_fall", fall_pulse, e.fall);
                chk("ev_capture", edge_capture, e.cap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk("rst_sw_out", sw_out, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_capture", edge_capture, 0);
        chk("rst_irq", irq, 0);

        reset_n = 1'b1;
        expect_ev(8'hFF, 8'hFF, 8'h00, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("post_reset_hold", sw_out, 0);
        end
        tick(1);
        chk("irq_lags_capture", irq, 0);
        tick(1);
        chk("irq_after_capture", irq, 1);

        edge_clr = 8'hFF;
        tick(1);
        edge_clr = 8'h00;
        chk("clear_all", edge_capture, 0);
        tick(1);
        chk("irq_after_clear", irq, 0);

        sw_raw = 8'h00;
        expect_ev(8'h00, 8'h00, 8'hFF, 8'hFF);
        tick(8);
        edge_clr = 8'hFF;
        tick(1);
        edge_clr = 8'h00;

        sw_raw = 8'h01;
        tick(3);
        sw_raw = 8'h00;
        tick(10);
        chk("glitch_sw_out", sw_out, 0);
        chk("glitch_capture", edge_capture, 0);

        for (int i = 0; i < 10; i++) begin
            sw_raw[3] = ~sw_raw[3];
            tick(1);
        end
        sw_raw[3] = 1'b1;
        expect_ev(8'h08, 8'h08, 8'h00, 8'h08);
        tick(10);
        chk("chatter_sw_out", sw_out, 8'h08);

        sw_raw = 8'h0C;
        expect_ev(8'h0C, 8'h04, 8'h00, 8'h0C);
        tick(5);
        edge_clr = 8'h04;
        tick(1);
        edge_clr = 8'h00;
        chk("set_beats_clear", edge_capture[2], 1);
        tick(2);
        edge_clr = 8'h04;
        tick(1);
        edge_clr = 8'h00;
        chk("clear_alone", edge_capture, 8'h08);

        edge_clr = 8'hFF;
        irq_mask = 8'h00;
        tick(1);
        edge_clr = 8'h00;
        sw_raw = 8'h1C;
        expect_ev(8'h1C, 8'h10, 8'h00, 8'h10);
        tick(8);
        chk("masked_capture", edge_capture, 8'h10);
        chk("masked_irq", irq, 0);
        irq_mask = 8'h10;
        tick(1);
        chk("unmasked_irq", irq, 1);

        sw_raw = 8'h3C;
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("async_rst_sw_out", sw_out, 0);
        chk("async_rst_rise", rise_pulse, 0);
        chk("async_rst_fall", fall_pulse, 0);
        chk("async_rst_capture", edge_capture, 0);
        chk("async_rst_irq", irq, 0);
        tick(1);
        reset_n = 1'b1;
        expect_ev(8'h3C, 8'h3C, 8'h00, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rst_discard_hold", sw_out, 0);
        end
        tick(3);
        chk("rst_final_sw_out", sw_out, 8'h3C);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: the number of switch bits, matching the 8-bit switch PIO input it feeds.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): the number of consecutive stable cycles required; legal range is 1 and above.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port sw_raw, input, WIDTH bits: raw, asynchronous, bouncing switch levels.
REQ-006 The block SHALL have port sw_out, output, WIDTH bits: debounced levels, which drive the switch PIO in_port.
REQ-007 The block SHALL have port rise_pulse, output, WIDTH bits: one-cycle pulse per bit when that bit of sw_out goes 0->1.
REQ-008 The block SHALL have port fall_pulse, output, WIDTH bits: one-cycle pulse per bit when that bit of sw_out goes 1->0.
REQ-009 The block SHALL have port edge_clr, input, WIDTH bits: write-1-to-clear strobe for edge_capture, sampled every cycle.
REQ-010 The block SHALL have port irq_mask, input, WIDTH bits: per-bit interrupt enable.
REQ-011 The block SHALL have port edge_capture, output, WIDTH bits: sticky record of any debounced edge.
REQ-012 The block SHALL have port irq, output, 1 bit: OR-reduction of (edge_capture & irq_mask).

Function
REQ-013 Each sw_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use; there SHALL be no combinational path from sw_raw to any output.
REQ-014 Each bit SHALL own an independent stability counter of width ceil(log2(DEBOUNCE_CYCLES+1)), which never wraps.
REQ-015 When s2 differs from sw_out and count != DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When s2 differs from sw_out and count == DEBOUNCE_CYCLES-1, the block SHALL, on the same edge, toggle sw_out, clear the counter to 0, and assert the matching rise_pulse or fall_pulse bit.
REQ-017 When s2 equals sw_out, the counter SHALL clear to 0; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-018 Latency: counting the edge that first samples a new stable level as edge 1, sw_out SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-019 rise_pulse and fall_pulse SHALL be registered, high exactly the one cycle in which sw_out first shows the new value, and never simultaneously high for the same bit.
REQ-020 On a debounced edge, edge_capture[i] SHALL set, and SHALL stay set until edge_clr[i]=1; if set and clear occur in the same cycle, set SHALL win.
REQ-021 irq SHALL be registered, updating one cycle after edge_capture or irq_mask changes.
REQ-022 All bits SHALL operate fully independently; simultaneous edges on several bits SHALL all be reported in the same cycle.

Reset
REQ-023 While reset_n=0, s1, s2, all counters, sw_out, rise_pulse, fall_pulse, edge_capture and irq SHALL be 0, asynchronously.
REQ-024 Reset release SHALL be synchronous in effect, and a reset mid-count SHALL discard the partial count.
REQ-025 After reset, switches held high SHALL be treated as 0->1 edges, raising rise_pulse and setting edge_capture.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-026 Scenario: sw_raw=8'hFF through reset, then release -> sw_out=8'h00 for 5 edges, sw_out=8'hFF at edge 6, rise_pulse=8'hFF for 1 cycle, edge_capture=8'hFF, irq=1 one cycle later with irq_mask=8'hFF.
REQ-027 Scenario: bit0 high for 3 cycles then low -> sw_out, pulses and edge_capture remain 8'h00.
REQ-028 Scenario: bit3 toggles every cycle for 10 cycles, then holds 1 -> exactly one rise_pulse[3], exactly 6 edges after the final transition; no fall_pulse.
REQ-029 Scenario: edge_clr[2]=1 in the same cycle a new edge on bit2 sets it -> edge_capture[2]=1 afterwards; edge_clr[2] alone in a later cycle -> 0.
REQ-030 Scenario: reset_n pulsed low when bit5 has count 3 -> all outputs 0 immediately; after release, a full 6-edge latency is required again.
REQ-031 Scenario: irq_mask=8'h00 with edge_capture=8'h10 -> irq=0; set irq_mask=8'h10 -> irq=1 one cycle later.
